// File: rtl/audio_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : audio_frame_buffer
//  Description : Collects a serial stream of 24-bit audio samples into
//                16-sample frames and presents each completed frame in
//                parallel to the downstream FFT stage. One fill buffer plus
//                one set of presentation registers lets filling continue
//                while the FFT works on the previous frame. Kept samples
//                that arrive while a full frame is still waiting for the
//                presentation registers are discarded and counted.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DECIM           keep every DECIM-th valid strobe (1..16)
//  Ports
//    Clk             in   1   system clock
//    Reset           in   1   asynchronous active-low reset
//    sample_in       in  24   two's complement sample, valid with sample_valid
//    sample_valid    in   1   one-cycle strobe per sample
//    frame_completed in   1   FFT has consumed the presented frame
//    s0..s15         out 24   presented frame, s0 oldest, s15 newest
//    Ready           out  1   presented frame valid and not yet consumed
//    drop_count      out  8   saturating count of discarded kept samples
// ============================================================================
module audio_frame_buffer #(
  parameter int DECIM = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [23:0] sample_in,
  input  logic        sample_valid,
  input  logic        frame_completed,
  output logic [23:0] s0,
  output logic [23:0] s1,
  output logic [23:0] s2,
  output logic [23:0] s3,
  output logic [23:0] s4,
  output logic [23:0] s5,
  output logic [23:0] s6,
  output logic [23:0] s7,
  output logic [23:0] s8,
  output logic [23:0] s9,
  output logic [23:0] s10,
  output logic [23:0] s11,
  output logic [23:0] s12,
  output logic [23:0] s13,
  output logic [23:0] s14,
  output logic [23:0] s15,
  output logic        Ready,
  output logic [7:0]  drop_count
);

  localparam logic [4:0] DECIM_LAST = 5'(DECIM - 1);

  // The enum value doubles as the Ready flag, so Ready comes straight
  // from a flop with no decode logic.
  typedef enum logic {
    EMPTY   = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t      state;
  logic [23:0] fill [16];
  logic [23:0] pres [16];
  logic [3:0]  wp;
  logic        full_pending;
  logic [4:0]  decim_cnt;

  logic kept;
  logic copy_now;
  logic write_now;
  logic overrun;

  assign kept     = sample_valid && (decim_cnt == 5'd0);
  assign copy_now = full_pending && (state == EMPTY);
  // On a copy edge the fill buffer is being emptied into the presentation
  // registers, so a sample arriving on that same edge can start the next
  // frame at f[0] (wp is 0 whenever full_pending is set).
  assign write_now = kept && (!full_pending || copy_now);
  assign overrun   = kept && full_pending && !copy_now;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= EMPTY;
      wp           <= 4'd0;
      full_pending <= 1'b0;
      decim_cnt    <= 5'd0;
      drop_count   <= 8'd0;
      for (int i = 0; i < 16; i++) begin
        fill[i] <= 24'd0;
        pres[i] <= 24'd0;
      end
    end else begin
      if (sample_valid) begin
        decim_cnt <= (decim_cnt == DECIM_LAST) ? 5'd0 : decim_cnt + 5'd1;
      end

      // Clear first; a write that completes a frame on the same edge
      // cannot coincide with a copy (copy implies wp == 0).
      if (copy_now) begin
        full_pending <= 1'b0;
      end

      if (write_now) begin
        fill[wp] <= sample_in;
        wp       <= wp + 4'd1;  // wraps 15 -> 0
        if (wp == 4'd15) begin
          full_pending <= 1'b1;
        end
      end

      if (overrun && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end

      case (state)
        EMPTY: begin
          if (full_pending) begin
            for (int i = 0; i < 16; i++) begin
              pres[i] <= fill[i];
            end
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (frame_completed) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign Ready = (state == PRESENT);

  assign s0  = pres[0];
  assign s1  = pres[1];
  assign s2  = pres[2];
  assign s3  = pres[3];
  assign s4  = pres[4];
  assign s5  = pres[5];
  assign s6  = pres[6];
  assign s7  = pres[7];
  assign s8  = pres[8];
  assign s9  = pres[9];
  assign s10 = pres[10];
  assign s11 = pres[11];
  assign s12 = pres[12];
  assign s13 = pres[13];
  assign s14 = pres[14];
  assign s15 = pres[15];

endmodule
`default_nettype wire
